audio_level_meter: RTL and testbench

Multichannel, parametrised audio level meter that generalises the single-channel 256-sample volume FSM. Per channel, it computes the mean-absolute or peak magnitude over a window of 2^LOG2_WIN samples. It publishes each result as a raw magnitude and as an MSB-aligned thermometer bar. It sits between the audio sample stream and the display/level-driver logic, and accepts time-multiplexed channel-tagged samples through a valid/ready handshake.

---
 rtl/audio_level_meter.sv | 204 ++++++++++++++++++++
 tb/tb_audio_level_meter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_level_meter.sv
// Multichannel windowed audio level meter: mean-absolute or peak magnitude per channel, published as raw value + MSB-first bar.
// Latency: accepted sample is folded into its channel 1 cycle later; a window-closing sample publishes 2 edges after acceptance.
// Backpressure: ready is high only in IDLE, so one sample per 2 cycles (3 when a window closes); sample_valid is ignored while ready is low.
module audio_level_meter #(
    parameter int SAMPLE_W = 8,
    parameter int NUM_CH   = 2,
    parameter int LOG2_WIN = 8,
    parameter int LEVEL_W  = 8,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        sample_valid,
    input  logic [CH_W-1:0]             sample_ch,
    input  logic [SAMPLE_W-1:0]         sample,
    input  logic                        mode,
    output logic                        ready,
    output logic [NUM_CH*LEVEL_W-1:0]   level,
    output logic [SAMPLE_W-2:0]         magnitude,
    output logic                        level_valid,
    output logic [CH_W-1:0]             level_ch
);

    localparam int MAG_W = SAMPLE_W - 1;
    localparam int ACC_W = MAG_W + LOG2_WIN;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_PUBLISH = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [SAMPLE_W-1:0]        smp_q, smp_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic                       mode_q, mode_d;
    logic [ACC_W-1:0]           acc_q [NUM_CH];
    logic [ACC_W-1:0]           acc_d [NUM_CH];
    logic [LOG2_WIN-1:0]        cnt_q [NUM_CH];
    logic [LOG2_WIN-1:0]        cnt_d [NUM_CH];
    logic [NUM_CH-1:0]          mode_l_q, mode_l_d;
    logic [NUM_CH*LEVEL_W-1:0]  level_q, level_d;
    logic [MAG_W-1:0]           mag_q, mag_d;
    logic                       level_vld_q, level_vld_d;
    logic [CH_W-1:0]            level_ch_q, level_ch_d;

    logic                       accept;
    logic [MAG_W-1:0]           abs_val;
    logic [MAG_W-1:0]           pub_mag;
    logic                       eff_mode;

    // MSB-first thermometer: bar length tracks the position of the leading one.
    function automatic logic [LEVEL_W-1:0] therm(input logic [MAG_W-1:0] m);
        int msb;
        int lv;
        logic [LEVEL_W-1:0] bar;
        msb = -1;
        for (int i = 0; i < MAG_W; i++) begin
            if (m[i]) msb = i;
        end
        if (msb < 0) lv = 0;
        else         lv = msb + 1 + LEVEL_W - MAG_W;
        if (lv < 0)       lv = 0;
        if (lv > LEVEL_W) lv = LEVEL_W;
        bar = '0;
        for (int i = 0; i < LEVEL_W; i++) begin
            if (i >= LEVEL_W - lv) bar[i] = 1'b1;
        end
        return bar;
    endfunction

    // Absolute value of the registered sample; the most-negative code saturates to all-ones.
    always_comb begin
        abs_val = '0;
        if (!smp_q[SAMPLE_W-1]) begin
            abs_val = smp_q[MAG_W-1:0];
        end else if (smp_q[MAG_W-1:0] == '0) begin
            abs_val = '1;
        end else begin
            abs_val = MAG_W'(~smp_q + SAMPLE_W'(1));
        end
    end

    // FSM next state, per-channel accumulation, publish and synchronous clear.
    always_comb begin
        state_d     = state_q;
        smp_d       = smp_q;
        ch_d        = ch_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mode_l_d    = mode_l_q;
        level_d     = level_q;
        mag_d       = mag_q;
        level_ch_d  = level_ch_q;
        level_vld_d = 1'b0;
        pub_mag     = '0;
        eff_mode    = 1'b0;

        accept = sample_valid && (state_q == S_IDLE) && !clear;
        if (accept) begin
            smp_d  = sample;
            ch_d   = sample_ch;
            mode_d = mode;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                state_d = S_IDLE;
                // Out-of-range channel tags fall through without touching any channel.
                for (int c = 0; c < NUM_CH; c++) begin
                    if (int'(ch_q) == c) begin
                        // Mode is sampled only on the first sample of a window.
                        eff_mode = (cnt_q[c] == '0) ? mode_q : mode_l_q[c];
                        if (cnt_q[c] == '0) mode_l_d[c] = mode_q;
                        if (eff_mode) begin
                            if (ACC_W'(abs_val) > acc_q[c]) acc_d[c] = ACC_W'(abs_val);
                        end else begin
                            acc_d[c] = acc_q[c] + ACC_W'(abs_val);
                        end
                        cnt_d[c] = cnt_q[c] + LOG2_WIN'(1);
                        if (cnt_q[c] == '1) state_d = S_PUBLISH;
                    end
                end
            end
            S_PUBLISH: begin
                state_d = S_IDLE;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (int'(ch_q) == c) begin
                        if (mode_l_q[c]) pub_mag = acc_q[c][MAG_W-1:0];
                        else             pub_mag = acc_q[c][ACC_W-1:LOG2_WIN];
                        level_d[c*LEVEL_W +: LEVEL_W] = therm(pub_mag);
                        mag_d       = pub_mag;
                        level_ch_d  = ch_q;
                        level_vld_d = 1'b1;
                        acc_d[c]    = '0;
                        cnt_d[c]    = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clear flushes window state but keeps the last published result on the outputs.
        if (clear) begin
            state_d     = S_IDLE;
            mode_l_d    = '0;
            level_d     = level_q;
            mag_d       = mag_q;
            level_ch_d  = level_ch_q;
            level_vld_d = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_d[c] = '0;
                cnt_d[c] = '0;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            smp_q       <= '0;
            ch_q        <= '0;
            mode_q      <= 1'b0;
            mode_l_q    <= '0;
            level_q     <= '0;
            mag_q       <= '0;
            level_vld_q <= 1'b0;
            level_ch_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= '0;
                cnt_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            smp_q       <= smp_d;
            ch_q        <= ch_d;
            mode_q      <= mode_d;
            mode_l_q    <= mode_l_d;
            level_q     <= level_d;
            mag_q       <= mag_d;
            level_vld_q <= level_vld_d;
            level_ch_q  <= level_ch_d;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= acc_d[c];
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign level       = level_q;
    assign magnitude   = mag_q;
    assign level_valid = level_vld_q;
    assign level_ch    = level_ch_q;

endmodule

// File: tb/tb_audio_level_meter.sv
module tb_audio_level_meter;

    localparam int SAMPLE_W = 8;
    localparam int NUM_CH   = 2;
    localparam int LOG2_WIN = 8;
    localparam int LEVEL_W  = 8;
    localparam int CH_W     = 1;
    localparam int WIN      = 1 << LOG2_WIN;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       clear;
    logic                       sample_valid;
    logic [CH_W-1:0]            sample_ch;
    logic [SAMPLE_W-1:0]        sample;
    logic                       mode;
    logic                       ready;
    logic [NUM_CH*LEVEL_W-1:0]  level;
    logic [SAMPLE_W-2:0]        magnitude;
    logic                       level_valid;
    logic [CH_W-1:0]            level_ch;

    audio_level_meter #(
        .SAMPLE_W(SAMPLE_W), .NUM_CH(NUM_CH), .LOG2_WIN(LOG2_WIN), .LEVEL_W(LEVEL_W)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .sample_valid(sample_valid),
        .sample_ch(sample_ch), .sample(sample), .mode(mode), .ready(ready),
        .level(level), .magnitude(magnitude), .level_valid(level_valid), .level_ch(level_ch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int ch;
        int mag;
        int bar;
        int cyc;
    } pub_t;

    pub_t obs_q[$];
    pub_t exp_q[$];
    pub_t mon_p;

    // Capture every published result as seen on the outputs.
    always @(negedge clk) begin
        if (level_valid) begin
            mon_p.ch  = int'(level_ch);
            mon_p.mag = int'(magnitude);
            mon_p.bar = int'(level[8*level_ch +: 8]);
            mon_p.cyc = cyc;
            obs_q.push_back(mon_p);
        end
    end

    // Reference model: per-channel window statistics, kept as plain integers.
    int m_sum  [NUM_CH];
    int m_max  [NUM_CH];
    int m_cnt  [NUM_CH];
    int m_mode [NUM_CH];
    int m_level[NUM_CH];
    int m_mag;
    int m_ch;
    bit suppress_pub = 0;

    function automatic int exp_bar(input int m);
        int msb;
        int l;
        if (m == 0) return 0;
        msb = $clog2(m + 1) - 1;
        l = msb + 1 + LEVEL_W - (SAMPLE_W - 1);
        if (l < 0) l = 0;
        if (l > LEVEL_W) l = LEVEL_W;
        return ((1 << l) - 1) << (LEVEL_W - l);
    endfunction

    task automatic model_flush();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0; m_sum[c] = 0; m_max[c] = 0; m_mode[c] = 0;
        end
    endtask

    task automatic model_accept(input int ch, input int v, input int md);
        int a;
        int r;
        pub_t p;
        if (ch >= NUM_CH) return;
        a = (v < 0) ? -v : v;
        if (a > 127) a = 127;
        if (m_cnt[ch] == 0) begin
            m_mode[ch] = md; m_sum[ch] = 0; m_max[ch] = 0;
        end
        m_sum[ch] += a;
        if (a > m_max[ch]) m_max[ch] = a;
        m_cnt[ch]++;
        if (m_cnt[ch] == WIN) begin
            r = (m_mode[ch] != 0) ? m_max[ch] : (m_sum[ch] / WIN);
            m_cnt[ch] = 0;
            if (!suppress_pub) begin
                p.ch = ch; p.mag = r; p.bar = exp_bar(r); p.cyc = cyc + 2;
                exp_q.push_back(p);
                m_level[ch] = p.bar;
                m_mag = r;
                m_ch = ch;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Present one sample and hold it until the handshake completes; valid stays high afterwards.
    task automatic send(input int ch, input int v, input int md);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            chk("send_ready_timeout", 64'(ready), 64'd1);
            return;
        end
        sample_valid = 1'b1;
        sample_ch    = CH_W'(ch);
        sample       = SAMPLE_W'(v);
        mode         = md[0];
        @(posedge clk);
        #1;
        model_accept(ch, v, md);
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_pubs(input string tag);
        int n;
        chk({tag, "_pub_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_pub_ch"},  64'(obs_q[i].ch),  64'(exp_q[i].ch));
            chk({tag, "_pub_mag"}, 64'(obs_q[i].mag), 64'(exp_q[i].mag));
            chk({tag, "_pub_bar"}, 64'(obs_q[i].bar), 64'(exp_q[i].bar));
            chk({tag, "_pub_cyc"}, 64'(obs_q[i].cyc), 64'(exp_q[i].cyc));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_outs(input string tag);
        for (int c = 0; c < NUM_CH; c++) begin
            chk({tag, "_level"}, 64'(level[c*LEVEL_W +: LEVEL_W]), 64'(m_level[c]));
        end
        chk({tag, "_magnitude"}, 64'(magnitude), 64'(m_mag));
        chk({tag, "_level_ch"},  64'(level_ch),  64'(m_ch));
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ready"},       64'(ready),       64'd1);
        chk({tag, "_level"},       64'(level),       64'd0);
        chk({tag, "_magnitude"},   64'(magnitude),   64'd0);
        chk({tag, "_level_valid"}, 64'(level_valid), 64'd0);
        chk({tag, "_level_ch"},    64'(level_ch),    64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; sample_valid = 1'b0;
        sample_ch = '0; sample = '0; mode = 1'b0;
        model_flush();
        for (int c = 0; c < NUM_CH; c++) m_level[c] = 0;
        m_mag = 0; m_ch = 0;
        repeat (2) @(negedge clk);
        check_reset_outs("reset");
        reset = 1'b0;
        idle(2);

        // Mean mode on channel 0.
        for (int i = 0; i < WIN; i++) send(0, 64, 0);
        idle(4);
        check_pubs("mean");
        check_outs("mean");
        chk("mean_mag_const", 64'(magnitude), 64'h40);
        chk("mean_bar0_const", 64'(level[7:0]), 64'hFF);
        chk("mean_bar1_const", 64'(level[15:8]), 64'h00);

        // Most-negative sample saturates; a following zero window reads back zero.
        for (int i = 0; i < WIN; i++) send(1, -128, 0);
        idle(4);
        check_pubs("sat");
        chk("sat_mag_const", 64'(magnitude), 64'h7F);
        chk("sat_bar1_const", 64'(level[15:8]), 64'hFF);
        for (int i = 0; i < WIN; i++) send(1, 0, 0);
        idle(4);
        check_pubs("zero");
        chk("zero_mag_const", 64'(magnitude), 64'h00);
        chk("zero_bar1_const", 64'(level[15:8]), 64'h00);

        // Peak vs mean with a single -3 in a window of zeros.
        for (int i = 0; i < WIN - 1; i++) send(1, 0, 1);
        send(1, -3, 1);
        idle(4);
        check_pubs("peak");
        chk("peak_mag_const", 64'(magnitude), 64'd3);
        chk("peak_bar1_const", 64'(level[15:8]), 64'hE0);
        for (int i = 0; i < WIN - 1; i++) send(1, 0, 0);
        send(1, -3, 0);
        idle(4);
        check_pubs("meanpk");
        chk("meanpk_mag_const", 64'(magnitude), 64'd0);
        for (int i = 0; i < WIN - 1; i++) send(1, 0, (i < 10) ? 1 : 0);
        send(1, -3, 0);
        idle(4);
        check_pubs("toggle");
        chk("toggle_mag_const", 64'(magnitude), 64'd3);
        for (int i = 0; i < WIN - 1; i++) send(1, 0, (i < 10) ? 0 : 1);
        send(1, -3, 1);
        idle(4);
        check_pubs("toggle2");
        check_outs("toggle2");

        // Interleaved channels with sample_valid held high between handshakes.
        for (int i = 0; i < WIN; i++) begin
            send(0, 16, 0);
            send(1, 2, 0);
        end
        idle(4);
        check_pubs("ilv");
        chk("ilv_level_const", 64'(level), 64'hE0FC);
        chk("ilv_ch_const", 64'(level_ch), 64'd1);

        // Clear mid-window keeps outputs and restarts the window.
        for (int i = 0; i < 100; i++) send(0, 64, 0);
        idle(1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_flush();
        idle(3);
        check_pubs("clr");
        check_outs("clr");
        for (int i = 0; i < WIN; i++) send(0, 8, 0);
        idle(4);
        check_pubs("clr8");
        chk("clr8_mag_const", 64'(magnitude), 64'h08);
        chk("clr8_bar0_const", 64'(level[7:0]), 64'hF8);

        // Clear landing on the PUBLISH cycle suppresses the result.
        for (int i = 0; i < WIN - 1; i++) send(0, 5, 0);
        suppress_pub = 1;
        send(0, 5, 0);
        sample_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("clrpub_busy", 64'(ready), 64'd0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        suppress_pub = 0;
        model_flush();
        idle(3);
        check_pubs("clrpub");
        check_outs("clrpub");
        for (int i = 0; i < WIN; i++) send(1, 1, 1);
        idle(4);
        check_pubs("afterclr");
        check_outs("afterclr");

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 50; i++) send(0, int'($urandom_range(0, 255)) - 128, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outs("rstmid");
        @(posedge clk);
        #1;
        check_reset_outs("rsthold");
        @(negedge clk);
        reset = 1'b0;
        sample_valid = 1'b0;
        model_flush();
        for (int c = 0; c < NUM_CH; c++) m_level[c] = 0;
        m_mag = 0; m_ch = 0;
        obs_q.delete();
        for (int i = 0; i < WIN - 1; i++) send(0, 7, 0);
        idle(4);
        check_pubs("rst255");
        send(0, 7, 0);
        idle(4);
        check_pubs("rst256");
        check_outs("rst256");

        // Randomised mixed traffic against the model.
        for (int i = 0; i < 1200; i++) begin
            int v;
            v = int'($urandom_range(0, 255)) - 128;
            v = v >>> $urandom_range(0, 6);
            send(int'($urandom_range(0, NUM_CH - 1)), v, int'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(4);
        check_pubs("rand");
        check_outs("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
